// File: rtl/ack_bus_scheduler.sv
// ack_bus_scheduler
//   Grants a shared acknowledge bus to one of four requesters (CTRL, AES, SHA, MEM).
//   The bus runs through three states: IDLE (arbitrate), GRANT (hold winner) and
//   RELEASE (one turnaround cycle). A grant is forcibly released after
//   TIMEOUT_CYCLES cycles, and timeout_err pulses for one cycle when that happens.
//
//   Build option: define ACK_ARB_ROUND_ROBIN_EN for rotating priority. When it is
//   undefined the priority is fixed at CTRL > AES > SHA > MEM.
//
// Ports
//   clk                  in   single clock; all state changes on the rising edge
//   rst                  in   synchronous, active-high reset
//   ack_valid_from_*     in   request from each source; held high until granted
//   ack_ready_to_*       out  registered grant, at most one high per cycle
//   ack_valid_n          out  active-low bus busy; 0 while a grant is active
//   winner_source_id     out  granted ID (MEM 00, SHA 01, AES 10, CTRL 11);
//                             reads 11 in IDLE and RELEASE
//   timeout_err          out  one-cycle pulse on a forced release
module ack_bus_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack_valid_from_ctrl,
  input  logic       ack_valid_from_aes,
  input  logic       ack_valid_from_sha,
  input  logic       ack_valid_from_mem,
  output logic       ack_ready_to_ctrl,
  output logic       ack_ready_to_aes,
  output logic       ack_ready_to_sha,
  output logic       ack_ready_to_mem,
  output logic       ack_valid_n,
  output logic [1:0] winner_source_id,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [1:0] ID_CTRL  = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  logic [1:0] win_q;
  logic [7:0] cnt_q;
  logic [3:0] ready_q;     // indexed by source ID
  logic       busy_n_q;
  logic [1:0] id_q;
  logic       tmo_q;
  logic [3:0] req;
  logic       any_req;
  logic [1:0] pick;

`ifdef ACK_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q;
`endif

  assign req     = {ack_valid_from_ctrl, ack_valid_from_aes,
                    ack_valid_from_sha, ack_valid_from_mem};
  assign any_req = |req;

`ifdef ACK_ARB_ROUND_ROBIN_EN
  // Search starts just after the last winner and wraps, so a reset value of CTRL
  // yields MEM > SHA > AES > CTRL. The loop runs from lowest to highest priority
  // so the highest-priority live request is the one left in pick.
  always_comb begin
    logic [1:0] idx;
    pick = ID_CTRL;
    idx  = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) pick = idx;
    end
  end
`else
  always_comb begin
    if (req[3])      pick = 2'd3;
    else if (req[2]) pick = 2'd2;
    else if (req[1]) pick = 2'd1;
    else             pick = 2'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= ID_CTRL;
      cnt_q    <= '0;
      ready_q  <= '0;
      busy_n_q <= 1'b1;
      id_q     <= ID_CTRL;
      tmo_q    <= 1'b0;
`ifdef ACK_ARB_ROUND_ROBIN_EN
      last_q   <= ID_CTRL;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_q <= 1'b0;
          if (any_req) begin
            state_q  <= S_GRANT;
            win_q    <= pick;
            cnt_q    <= '0;
            ready_q  <= 4'b0001 << pick;
            busy_n_q <= 1'b0;
            id_q     <= pick;
`ifdef ACK_ARB_ROUND_ROBIN_EN
            last_q   <= pick;
`endif
          end
        end

        S_GRANT: begin
          // A dropped request wins over a simultaneous timeout: no error pulse.
          if (!req[win_q] || cnt_q == CNT_LAST) begin
            state_q  <= S_RELEASE;
            ready_q  <= '0;
            busy_n_q <= 1'b1;
            id_q     <= ID_CTRL;
            tmo_q    <= req[win_q];
          end else begin
            cnt_q    <= cnt_q + 8'd1;
          end
        end

        S_RELEASE: begin
          state_q <= S_IDLE;
          tmo_q   <= 1'b0;
        end

        default: begin
          state_q  <= S_IDLE;
          ready_q  <= '0;
          busy_n_q <= 1'b1;
          id_q     <= ID_CTRL;
          tmo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack_ready_to_mem  = ready_q[0];
  assign ack_ready_to_sha  = ready_q[1];
  assign ack_ready_to_aes  = ready_q[2];
  assign ack_ready_to_ctrl = ready_q[3];
  assign ack_valid_n       = busy_n_q;
  assign winner_source_id  = id_q;
  assign timeout_err       = tmo_q;

endmodule
